// File: rtl/riscv_pkg.sv
// RV32I encoding constants and field types shared by the decode and encode stages.
package riscv_pkg;

    typedef enum logic [3:0] {
        KIND_ALU     = 4'd0,
        KIND_ALU_IMM = 4'd1,
        KIND_LOAD    = 4'd2,
        KIND_STORE   = 4'd3,
        KIND_BRANCH  = 4'd4,
        KIND_LUI     = 4'd5,
        KIND_AUIPC   = 4'd6,
        KIND_JAL     = 4'd7,
        KIND_JALR    = 4'd8
    } instr_kind_e;

    localparam logic [6:0] OPC_ALU     = 7'b0110011;
    localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;
    localparam logic [3:0] BR_BEQ   = 4'hA;
    localparam logic [3:0] BR_BNE   = 4'hB;
    localparam logic [3:0] BR_BLT   = 4'hC;
    localparam logic [3:0] BR_BGE   = 4'hD;
    localparam logic [3:0] BR_BLTU  = 4'hE;
    localparam logic [3:0] BR_BGEU  = 4'hF;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_BAD  = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        instr_kind_e kind;
        logic [3:0]  alu_op;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } instr_fields_t;

    // Register/immediate ALU ops share funct3; branches reuse the upper code range.
    function automatic logic [2:0] alu_funct3(input logic [3:0] op);
        case (op)
            ALU_ADD, ALU_SUB: return 3'b000;
            ALU_SLL:          return 3'b001;
            ALU_SLT:          return 3'b010;
            ALU_SLTU:         return 3'b011;
            ALU_XOR:          return 3'b100;
            ALU_SRL, ALU_SRA: return 3'b101;
            ALU_OR:           return 3'b110;
            ALU_AND:          return 3'b111;
            BR_BEQ:           return 3'b000;
            BR_BNE:           return 3'b001;
            BR_BLT:           return 3'b100;
            BR_BGE:           return 3'b101;
            BR_BLTU:          return 3'b110;
            BR_BGEU:          return 3'b111;
            default:          return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational bit packer: already-validated fields -> 32-bit RV32I word.
module instr_pack
    import riscv_pkg::*;
(
    input  instr_fields_t f,
    output logic [31:0]   instr
);

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_shift;
    logic [11:0] imm_i_field;

    always_comb begin
        funct3      = alu_funct3(f.alu_op);
        funct7      = (f.alu_op == ALU_SUB || f.alu_op == ALU_SRA) ? 7'b0100000 : 7'b0000000;
        is_shift    = (f.alu_op == ALU_SLL) || (f.alu_op == ALU_SRL) || (f.alu_op == ALU_SRA);
        // Shift-immediates carry the SRA marker in the top of the I immediate.
        imm_i_field = is_shift ? {funct7, f.imm[4:0]} : f.imm[11:0];
        instr       = NOP_INSTR;
        case (f.kind)
            KIND_ALU:
                instr = {funct7, f.rs2, f.rs1, funct3, f.rd, OPC_ALU};
            KIND_ALU_IMM:
                instr = {imm_i_field, f.rs1, funct3, f.rd, OPC_ALU_IMM};
            KIND_LOAD:
                instr = {f.imm[11:0], f.rs1, f.mem_unsigned, f.mem_size, f.rd, OPC_LOAD};
            KIND_STORE:
                instr = {f.imm[11:5], f.rs2, f.rs1, 1'b0, f.mem_size, f.imm[4:0], OPC_STORE};
            KIND_BRANCH:
                instr = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, funct3,
                         f.imm[4:1], f.imm[11], OPC_BRANCH};
            KIND_LUI:
                instr = {f.imm[31:12], f.rd, OPC_LUI};
            KIND_AUIPC:
                instr = {f.imm[31:12], f.rd, OPC_AUIPC};
            KIND_JAL:
                instr = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, OPC_JAL};
            KIND_JALR:
                instr = {f.imm[11:0], f.rs1, 3'b000, f.rd, OPC_JALR};
            default:
                instr = NOP_INSTR;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder: S1 checks field legality, S2 packs and registers the word.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [3:0]            kind_i,
    input  logic [3:0]            alu_op_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic                  err_o,
    output logic [ERR_CNT_W-1:0]  err_count_o
);

    logic          v1, v2, adv1, adv2;
    logic          s1_illegal, illegal;
    instr_fields_t s1_fields, req_fields;
    logic [31:0]   packed_word;
    logic          fits_i, fits_b, fits_j, fits_shamt, is_shift;

    assign adv2          = !v2 || instr_ready_i;
    assign adv1          = !v1 || adv2;
    assign req_ready_o   = adv1 && rst_n;
    assign instr_valid_o = v2;

    always_comb begin
        req_fields = '{kind:         instr_kind_e'(kind_i),
                       alu_op:       alu_op_i,
                       mem_size:     mem_size_i,
                       mem_unsigned: mem_unsigned_i,
                       rd:           rd_i,
                       rs1:          rs1_i,
                       rs2:          rs2_i,
                       imm:          imm_i};
    end

    // Range checks reduce to "upper bits are a pure sign extension" of the immediate.
    always_comb begin
        fits_i     = (&imm_i[31:11]) || !(|imm_i[31:11]);
        fits_b     = ((&imm_i[31:12]) || !(|imm_i[31:12])) && !imm_i[0];
        fits_j     = ((&imm_i[31:20]) || !(|imm_i[31:20])) && !imm_i[0];
        fits_shamt = !(|imm_i[31:5]);
        is_shift   = (alu_op_i == ALU_SLL) || (alu_op_i == ALU_SRL) || (alu_op_i == ALU_SRA);
        illegal    = 1'b1;
        case (instr_kind_e'(kind_i))
            KIND_ALU:     illegal = alu_op_i > ALU_AND;
            KIND_ALU_IMM: illegal = (alu_op_i == ALU_SUB) || (alu_op_i > ALU_AND) ||
                                    (is_shift ? !fits_shamt : !fits_i);
            KIND_LOAD:    illegal = (mem_size_i == MEM_BAD) ||
                                    (mem_unsigned_i && mem_size_i == MEM_WORD) || !fits_i;
            KIND_STORE:   illegal = (mem_size_i == MEM_BAD) || mem_unsigned_i || !fits_i;
            KIND_BRANCH:  illegal = (alu_op_i < BR_BEQ) || !fits_b;
            KIND_LUI,
            KIND_AUIPC:   illegal = |imm_i[11:0];
            KIND_JAL:     illegal = !fits_j;
            KIND_JALR:    illegal = !fits_i;
            default:      illegal = 1'b1;
        endcase
    end

    instr_pack u_pack (
        .f     (s1_fields),
        .instr (packed_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            s1_illegal  <= 1'b0;
            s1_fields   <= '0;
            instr_o     <= '0;
            err_o       <= 1'b0;
            err_count_o <= '0;
        end else begin
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    instr_o <= s1_illegal ? NOP_INSTR : packed_word;
                    err_o   <= s1_illegal;
                end
            end
            if (adv1) begin
                v1 <= req_valid_i;
                if (req_valid_i) begin
                    s1_fields  <= req_fields;
                    s1_illegal <= illegal;
                    if (illegal && err_count_o != '1)
                        err_count_o <= err_count_o + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: field-level reference model, in-order scoreboard, directed literals and random traffic.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  kind_i = '0;
    logic [3:0]  alu_op_i = '0;
    logic [1:0]  mem_size_i = '0;
    logic        mem_unsigned_i = 1'b0;
    logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [31:0] imm_i = '0;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic        err_o;
    logic [15:0] err_count_o;

    instr_encoder #(.DATA_WIDTH(32), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .kind_i(kind_i), .alu_op_i(alu_op_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .imm_i(imm_i), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i), .err_o(err_o), .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  kind;
        logic [3:0]  op;
        logic [1:0]  sz;
        logic        un;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        logic [31:0] w;
        logic        e;
        req_t        r;
    } ent_t;

    ent_t        q[$];
    logic [15:0] cnt_m = '0;
    logic        rst_prev = 1'b1;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic req_t mk(int k, int op, int sz, int un, int rd, int rs1, int rs2, int imm);
        req_t r;
        r.kind = 4'(k); r.op = 4'(op); r.sz = 2'(sz); r.un = 1'(un);
        r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = 32'(imm);
        return r;
    endfunction

    function automatic bit is_shift_op(logic [3:0] op);
        return op == 4'd2 || op == 4'd6 || op == 4'd7;
    endfunction

    // Legality from the documented numeric ranges.
    function automatic bit model_err(req_t r);
        int s;
        s = $signed(r.imm);
        case (r.kind)
            4'd0: return r.op > 4'd9;
            4'd1: begin
                if (r.op == 4'd1 || r.op > 4'd9) return 1'b1;
                if (is_shift_op(r.op)) return s < 0 || s > 31;
                return s < -2048 || s > 2047;
            end
            4'd2: return r.sz == 2'd3 || (r.un && r.sz == 2'd2) || s < -2048 || s > 2047;
            4'd3: return r.sz == 2'd3 || r.un || s < -2048 || s > 2047;
            4'd4: return r.op < 4'd10 || s < -4096 || s > 4094 || r.imm[0];
            4'd5, 4'd6: return r.imm[11:0] != 12'd0;
            4'd7: return s < -1048576 || s > 1048574 || r.imm[0];
            4'd8: return s < -2048 || s > 2047;
            default: return 1'b1;
        endcase
    endfunction

    // Word built arithmetically from field positions; only called for legal requests.
    function automatic logic [31:0] model_word(req_t r);
        int          alu_f3[10];
        int          br_f3[6];
        logic [31:0] u, rd, rs1, rs2, f3, immf;
        alu_f3 = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        br_f3  = '{0, 1, 4, 5, 6, 7};
        u   = r.imm;
        rd  = 32'(r.rd) << 7;
        rs1 = 32'(r.rs1) << 15;
        rs2 = 32'(r.rs2) << 20;
        f3  = 32'(alu_f3[r.op < 4'd10 ? int'(r.op) : 0]) << 12;
        case (r.kind)
            4'd0: return 32'h33 + rd + f3 + rs1 + rs2 +
                         ((r.op == 4'd1 || r.op == 4'd7) ? 32'h4000_0000 : 32'h0);
            4'd1: begin
                if (is_shift_op(r.op)) immf = (u & 32'd31) + ((r.op == 4'd7) ? 32'h400 : 32'h0);
                else immf = u & 32'hFFF;
                return 32'h13 + rd + f3 + rs1 + (immf << 20);
            end
            4'd2: return 32'h03 + rd + ((32'(r.sz) + (r.un ? 32'd4 : 32'd0)) << 12) + rs1 +
                         ((u & 32'hFFF) << 20);
            4'd3: return 32'h23 + ((u & 32'd31) << 7) + (32'(r.sz) << 12) + rs1 + rs2 +
                         (((u >> 5) & 32'd127) << 25);
            4'd4: return 32'h63 + (((u >> 11) & 32'd1) << 7) + (((u >> 1) & 32'd15) << 8) +
                         (32'(br_f3[r.op >= 4'd10 ? int'(r.op) - 10 : 0]) << 12) + rs1 + rs2 +
                         (((u >> 5) & 32'd63) << 25) + (((u >> 12) & 32'd1) << 31);
            4'd5: return 32'h37 + rd + (u & 32'hFFFF_F000);
            4'd6: return 32'h17 + rd + (u & 32'hFFFF_F000);
            4'd7: return 32'h6F + rd + (((u >> 12) & 32'd255) << 12) + (((u >> 11) & 32'd1) << 20) +
                         (((u >> 1) & 32'd1023) << 21) + (((u >> 20) & 32'd1) << 31);
            4'd8: return 32'h67 + rd + rs1 + ((u & 32'hFFF) << 20);
            default: return 32'h13;
        endcase
    endfunction

    function automatic logic [31:0] model_out(req_t r);
        return model_err(r) ? 32'h0000_0013 : model_word(r);
    endfunction

    // Independent decode of the emitted word back to opcode, registers and immediate.
    function automatic bit roundtrip_ok(logic [31:0] w, req_t r);
        logic [31:0] im_i, im_s, im_b, im_u, im_j;
        im_i = {{20{w[31]}}, w[31:20]};
        im_s = {{20{w[31]}}, w[31:25], w[11:7]};
        im_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        im_u = {w[31:12], 12'd0};
        im_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (r.kind)
            4'd0: return w[6:0] == 7'h33 && w[11:7] == r.rd && w[19:15] == r.rs1 && w[24:20] == r.rs2;
            4'd1: return w[6:0] == 7'h13 && w[11:7] == r.rd && w[19:15] == r.rs1 &&
                         (is_shift_op(r.op) ? w[24:20] == r.imm[4:0] : im_i == r.imm);
            4'd2: return w[6:0] == 7'h03 && w[11:7] == r.rd && w[19:15] == r.rs1 &&
                         w[14:12] == {r.un, r.sz} && im_i == r.imm;
            4'd3: return w[6:0] == 7'h23 && w[19:15] == r.rs1 && w[24:20] == r.rs2 &&
                         w[14:12] == {1'b0, r.sz} && im_s == r.imm;
            4'd4: return w[6:0] == 7'h63 && w[19:15] == r.rs1 && w[24:20] == r.rs2 && im_b == r.imm;
            4'd5: return w[6:0] == 7'h37 && w[11:7] == r.rd && im_u == r.imm;
            4'd6: return w[6:0] == 7'h17 && w[11:7] == r.rd && im_u == r.imm;
            4'd7: return w[6:0] == 7'h6F && w[11:7] == r.rd && im_j == r.imm;
            4'd8: return w[6:0] == 7'h67 && w[11:7] == r.rd && w[19:15] == r.rs1 && im_i == r.imm;
            default: return 1'b0;
        endcase
    endfunction

    function automatic req_t gen_req();
        req_t r;
        int   bnd[16];
        int   mode;
        bnd = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 4095, -4098,
                1048574, -1048576, 1048576, 1048575, 31, 32, -1};
        r.kind = 4'($urandom_range(0, 8));
        r.rd   = 5'($urandom);
        r.rs1  = 5'($urandom);
        r.rs2  = 5'($urandom);
        r.sz   = 2'($urandom_range(0, 2));
        r.un   = 1'b0;
        case (r.kind)
            4'd0, 4'd1: r.op = 4'($urandom_range(0, 10));
            4'd4:       r.op = 4'($urandom_range(9, 15));
            default:    r.op = 4'($urandom);
        endcase
        if (r.kind == 4'd2 || r.kind == 4'd3) begin
            r.sz = 2'($urandom_range(0, 3));
            r.un = ($urandom_range(0, 3) == 0);
        end
        mode = $urandom_range(0, 9);
        if (mode == 0) r.imm = $urandom;
        else if (mode == 1) r.imm = 32'(bnd[$urandom_range(0, 15)]);
        else begin
            case (r.kind)
                4'd1: r.imm = is_shift_op(r.op) ? 32'($urandom_range(0, 31))
                                                : 32'($urandom_range(0, 4095)) - 32'd2048;
                4'd2, 4'd3, 4'd8: r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                4'd4: r.imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
                4'd5, 4'd6: r.imm = $urandom & 32'hFFFF_F000;
                4'd7: r.imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
                default: r.imm = $urandom;
            endcase
        end
        return r;
    endfunction

    task automatic apply(input req_t r);
        kind_i = r.kind; alu_op_i = r.op; mem_size_i = r.sz; mem_unsigned_i = r.un;
        rd_i = r.rd; rs1_i = r.rs1; rs2_i = r.rs2; imm_i = r.imm;
    endtask

    function automatic req_t cur_req();
        req_t r;
        r.kind = kind_i; r.op = alu_op_i; r.sz = mem_size_i; r.un = mem_unsigned_i;
        r.rd = rd_i; r.rs1 = rs1_i; r.rs2 = rs2_i; r.imm = imm_i;
        return r;
    endfunction

    // Compare against the scoreboard, then predict what the coming edge does.
    always @(negedge clk) begin
        ent_t e;
        if (!rst_prev) begin
            chk("rst_valid", instr_valid_o, 0);
            chk("rst_instr", instr_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_count", err_count_o, 0);
        end else begin
            chk("err_count", err_count_o, cnt_m);
            if (instr_valid_o) begin
                if (q.size() == 0) chk("valid_without_pending", instr_valid_o, 0);
                else begin
                    chk("word", instr_o, q[0].w);
                    chk("err", err_o, q[0].e);
                end
            end
        end
        chk("req_ready", req_ready_o, rst_n && (q.size() < 2 || instr_ready_i));
        if (!rst_n) begin
            q.delete();
            cnt_m = '0;
        end else begin
            if (instr_valid_o && instr_ready_i && q.size() > 0) begin
                if (!q[0].e) chk("roundtrip", roundtrip_ok(instr_o, q[0].r), 1);
                void'(q.pop_front());
            end
            if (req_valid_i && req_ready_o) begin
                e.r = cur_req();
                e.e = model_err(e.r);
                e.w = model_out(e.r);
                q.push_back(e);
                if (e.e && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            end
        end
        rst_prev = rst_n;
    end

    // Single request with literal expectation; also pins the model to the same literal.
    task automatic run_lit(input string nm, input req_t r, input logic [31:0] exp_w, input logic exp_e);
        chk({nm, "_model_word"}, model_out(r), exp_w);
        chk({nm, "_model_err"}, model_err(r), exp_e);
        apply(r);
        req_valid_i = 1'b1;
        @(negedge clk);
        chk({nm, "_ready"}, req_ready_o, 1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk({nm, "_not_early"}, instr_valid_o, 0);
        @(negedge clk);
        chk({nm, "_valid"}, instr_valid_o, 1);
        chk({nm, "_word"}, instr_o, exp_w);
        chk({nm, "_err"}, err_o, exp_e);
        @(posedge clk); #1;
    endtask

    initial begin
        req_t bp[3];
        logic [31:0] hold;
        bit   have_hold;
        bit   acc;
        int   idx;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_lit("alu_add", mk(0, 0, 0, 0, 3, 1, 2, 0), 32'h002081B3, 1'b0);
        run_lit("addi_m1", mk(1, 0, 0, 0, 1, 0, 0, -1), 32'hFFF00093, 1'b0);
        run_lit("srai_3", mk(1, 7, 0, 0, 5, 5, 0, 3), 32'h4032D293, 1'b0);
        run_lit("sw_8", mk(3, 0, 2, 0, 0, 1, 2, 8), 32'h0020A423, 1'b0);
        run_lit("beq_m4", mk(4, 10, 0, 0, 0, 1, 2, -4), 32'hFE208EE3, 1'b0);
        run_lit("jal_2048", mk(7, 0, 0, 0, 1, 0, 0, 2048), 32'h001000EF, 1'b0);
        run_lit("addi_2048", mk(1, 0, 0, 0, 1, 0, 0, 2048), 32'h00000013, 1'b1);
        chk("count_after_first_illegal", err_count_o, 1);
        run_lit("beq_odd", mk(4, 10, 0, 0, 0, 1, 2, 3), 32'h00000013, 1'b1);
        chk("count_after_second_illegal", err_count_o, 2);
        run_lit("jalr_op_ignored", mk(8, 5, 0, 0, 1, 2, 0, 16), 32'h010100E7, 1'b0);
        run_lit("lui", mk(5, 0, 0, 0, 7, 0, 0, 32'h12345000), 32'h123453B7, 1'b0);
        run_lit("sb_min", mk(3, 0, 0, 0, 0, 3, 4, -2048), 32'h80418023, 1'b0);
        run_lit("slli_32", mk(1, 2, 0, 0, 1, 1, 0, 32), 32'h00000013, 1'b1);
        run_lit("lw_unsigned", mk(2, 0, 2, 1, 1, 1, 0, 0), 32'h00000013, 1'b1);

        // Backpressure: three offers, only two fit.
        bp[0] = mk(0, 0, 0, 0, 10, 1, 2, 0);
        bp[1] = mk(0, 1, 0, 0, 11, 3, 4, 0);
        bp[2] = mk(0, 9, 0, 0, 12, 5, 6, 0);
        instr_ready_i = 1'b0;
        idx = 0;
        have_hold = 1'b0;
        hold = '0;
        for (int c = 0; c < 5; c++) begin
            apply(bp[idx < 3 ? idx : 2]);
            req_valid_i = (idx < 3);
            @(negedge clk);
            acc = req_valid_i && req_ready_o;
            if (instr_valid_o) begin
                if (have_hold) chk("bp_stable", instr_o, hold);
                hold = instr_o;
                have_hold = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 2);
        @(negedge clk);
        chk("bp_ready_low", req_ready_o, 0);
        @(posedge clk); #1;
        instr_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_out0_valid", instr_valid_o, 1);
        chk("bp_out0", instr_o, model_out(bp[0]));
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("bp_out1_valid", instr_valid_o, 1);
        chk("bp_out1", instr_o, model_out(bp[1]));
        @(negedge clk);
        chk("bp_out2_valid", instr_valid_o, 1);
        chk("bp_out2", instr_o, model_out(bp[2]));
        @(posedge clk); #1;

        // Reset with two words in flight.
        instr_ready_i = 1'b0;
        apply(mk(0, 5, 0, 0, 1, 2, 3, 0));
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        apply(mk(1, 8, 0, 0, 4, 5, 0, 100));
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        instr_ready_i = 1'b1;
        @(negedge clk);
        chk("rst_flush_valid", instr_valid_o, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_no_stale", instr_valid_o, 0);
        end
        @(posedge clk); #1;

        // Random traffic with random downstream stalls.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc = req_valid_i && req_ready_o;
            @(posedge clk); #1;
            if (!req_valid_i || acc) begin
                req_valid_i = ($urandom_range(0, 9) < 7);
                if (req_valid_i) apply(gen_req());
            end
            instr_ready_i = ($urandom_range(0, 9) < 7);
        end

        req_valid_i = 1'b0;
        instr_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
